// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte sources.
// It supports optional packet locking with a lock timeout, and a programmable idle gap between frames.
module uart_tx_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int DATA_WIDTH        = 8,
  parameter int GAP_CLKS          = 0,
  parameter int LOCK_TIMEOUT_CLKS = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          locked,
  output logic                          busy,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_din,
  input  logic                          tx_done
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CLKS + 2);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT_CLKS + 2);

  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CLKS > 0) ? GAP_W'(GAP_CLKS - 1) : '0;
  localparam logic [TO_W-1:0]  TO_LAST  = (LOCK_TIMEOUT_CLKS > 0) ? TO_W'(LOCK_TIMEOUT_CLKS - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_grant;
  logic                  r_locked;
  logic [DATA_WIDTH-1:0] r_din;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [TO_W-1:0]       r_to_cnt;

  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
  logic [ID_W-1:0]       w_sel;
  logic                  w_sel_found;
  logic [ID_W:0]         w_sum;
  logic                  w_hs;
  logic [ID_W-1:0]       w_ptr_nxt;
  logic                  w_to_idle;
  logic                  w_to_fire;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_data[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Locked: only the owner may be granted. Unlocked: the first valid requester at or after r_ptr.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can leave it unassigned and infer a latch.
    w_sel       = '0;
    w_sel_found = 1'b0;
    w_sum       = '0;
    if (r_locked) begin
      w_sel       = r_grant;
      w_sel_found = req_valid[r_grant];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
        if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
          w_sum = w_sum - (ID_W+1)'(NUM_REQ);
        end
        if (!w_sel_found && req_valid[w_sum[ID_W-1:0]]) begin
          w_sel_found = 1'b1;
          w_sel       = w_sum[ID_W-1:0];
        end
      end
    end
  end

  assign w_hs      = reset && (r_state == S_IDLE) && w_sel_found;
  assign w_ptr_nxt = (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + ID_W'(1);
  assign req_ready = w_hs ? (NUM_REQ'(1) << w_sel) : '0;

  // Stalled lock: the owner is absent while the arbiter could otherwise accept a byte.
  assign w_to_idle = (LOCK_TIMEOUT_CLKS > 0) && (r_state == S_IDLE) && r_locked
                     && !req_valid[r_grant];
  assign w_to_fire = w_to_idle && (r_to_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_hs) w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_done) w_state_nxt = (GAP_CLKS > 0) ? S_GAP : S_IDLE;
      S_GAP:       if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so that every register updates from pre-edge values.
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_locked  <= 1'b0;
      r_din     <= '0;
      r_gap_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_hs) begin
        r_din    <= w_data[w_sel];
        r_grant  <= w_sel;
        r_ptr    <= w_ptr_nxt;
        r_locked <= ~req_last[w_sel];
      end else if (w_to_fire) begin
        r_locked <= 1'b0;
      end

      if ((r_state == S_WAIT_DONE) && tx_done) begin
        r_gap_cnt <= GAP_LOAD;
      end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end

      if (w_to_idle && !w_to_fire) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign grant_id = r_grant;
  assign locked   = r_locked;
  assign busy     = (r_state != S_IDLE);
  assign tx_start = (r_state == S_START);
  assign tx_din   = r_din;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed per-requester byte queues, a tx_done model,
// and a monitor that checks every tx_start against the hand-computed expected frame.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DW        = 8;
  localparam int GAP       = 5;
  localparam int TO        = 10;
  localparam int DONE_CLKS = 20;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } src_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    id;
    logic          lck;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [1:0]            grant_id;
  logic                  locked;
  logic                  busy;
  logic                  tx_start;
  logic [DW-1:0]         tx_din;
  logic                  tx_done;

  src_t src_q [NUM_REQ][$];
  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .GAP_CLKS(GAP), .LOCK_TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .grant_id(grant_id), .locked(locked),
    .busy(busy), .tx_start(tx_start), .tx_din(tx_din), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  task automatic load(input int id, input logic [DW-1:0] d, input logic l);
    src_t s;
    s.data = d;
    s.last = l;
    src_q[id].push_back(s);
  endtask

  task automatic expect_frame(input logic [DW-1:0] d, input logic [1:0] id, input logic lck);
    exp_t e;
    e.data = d;
    e.id   = id;
    e.lck  = lck;
    exp_q.push_back(e);
  endtask

  // Waits for tx_start (which=0) or tx_done (which=1), sampled at negedge; returns the cycle number.
  task automatic wait_for(input int which, input string name, output int at);
    int n = 0;
    logic hit;
    do begin
      @(negedge clk);
      n++;
      hit = (which == 0) ? tx_start : tx_done;
    end while (!hit && n < 300);
    at = cyc;
    if (!hit) fail_now(name);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || src_q[0].size() != 0 || src_q[1].size() != 0 ||
            src_q[2].size() != 0 || src_q[3].size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Requester driver: a byte leaves its queue after the edge that completed its handshake.
  initial begin
    logic [NUM_REQ-1:0] hs;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i]) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_valid[i]            = 1'b1;
          req_last[i]             = src_q[i][0].last;
          req_data[i*DW +: DW]    = src_q[i][0].data;
        end else begin
          req_valid[i]            = 1'b0;
          req_last[i]             = 1'b0;
          req_data[i*DW +: DW]    = '0;
        end
      end
    end
  end

  // uart_tx model: tx_done pulses DONE_CLKS cycles after each observed tx_start.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat (DONE_CLKS) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // Monitor: each start must match the next expected frame; tx_din must hold until tx_done.
  initial begin
    exp_t          e;
    logic [DW-1:0] last_din = '0;
    forever begin
      @(negedge clk);
      if (reset && tx_start) begin
        check("start_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_din", 32'(tx_din), 32'(e.data));
          check("grant_id", 32'(grant_id), 32'(e.id));
          check("locked", 32'(locked), 32'(e.lck));
        end
        last_din = tx_din;
      end
      if (reset && tx_done && busy) check("din_hold", 32'(tx_din), 32'(last_din));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_a, t_b, t_done;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_din", 32'(tx_din), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single requester.
    expect_frame(8'hA5, 2'd2, 1'b0);
    load(2, 8'hA5, 1'b1);
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'b0100);
    t_a = cyc;
    wait_for(0, "single_start", t_b);
    check("single_start_lat", 32'(t_b - t_a), 32'd1);
    check("single_busy_start", 32'(busy), 32'd1);
    wait_for(1, "single_done", t_done);
    check("single_busy_done", 32'(busy), 32'd1);
    check("single_unlocked", 32'(locked), 32'd0);
    drain("single_drain");

    // Fairness across requesters 0, 1 and 3.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      expect_frame(8'h10, 2'd0, 1'b0);
      expect_frame(8'h11, 2'd1, 1'b0);
      expect_frame(8'h13, 2'd3, 1'b0);
    end
    for (int r = 0; r < 2; r++) begin
      load(0, 8'h10, 1'b1);
      load(1, 8'h11, 1'b1);
      load(3, 8'h13, 1'b1);
    end
    drain("fair_drain");

    // Packet lock: requester 1 holds the serializer for its 3-byte packet.
    do_reset();
    expect_frame(8'h41, 2'd1, 1'b1);
    expect_frame(8'h42, 2'd1, 1'b1);
    expect_frame(8'h43, 2'd1, 1'b0);
    expect_frame(8'h30, 2'd0, 1'b0);
    load(1, 8'h41, 1'b0);
    load(1, 8'h42, 1'b0);
    load(1, 8'h43, 1'b1);
    t_a = 0;
    while (src_q[1].size() == 3 && t_a < 50) begin
      @(negedge clk);
      t_a++;
    end
    load(0, 8'h30, 1'b1);
    drain("lock_drain");

    // Gap: done cycle T, busy through T+5, idle at T+6, next start at T+7.
    do_reset();
    expect_frame(8'h55, 2'd2, 1'b0);
    expect_frame(8'h66, 2'd2, 1'b0);
    load(2, 8'h55, 1'b1);
    load(2, 8'h66, 1'b1);
    wait_for(0, "gap_start1", t_a);
    wait_for(1, "gap_done1", t_done);
    for (int d = 1; d <= GAP + 1; d++) begin
      @(negedge clk);
      check($sformatf("gap_busy_%0d", d), 32'(busy), (d <= GAP) ? 32'd1 : 32'd0);
    end
    wait_for(0, "gap_start2", t_b);
    check("gap_start_dist", 32'(t_b - t_done), 32'(GAP + 2));
    drain("gap_drain");

    // Lock timeout: owner 2 leaves a packet open; requester 3 waits.
    do_reset();
    expect_frame(8'h72, 2'd2, 1'b1);
    expect_frame(8'h73, 2'd3, 1'b0);
    load(2, 8'h72, 1'b0);
    load(3, 8'h73, 1'b1);
    wait_for(0, "to_start1", t_a);
    wait_for(1, "to_done1", t_done);
    for (int d = 1; d <= GAP + TO; d++) begin
      @(negedge clk);
      if (d == GAP + 1 || d == GAP + TO) begin
        check($sformatf("to_locked_%0d", d), 32'(locked), 32'd1);
        check($sformatf("to_noready_%0d", d), 32'(req_ready), 32'd0);
      end
    end
    @(negedge clk);
    check("to_unlocked", 32'(locked), 32'd0);
    check("to_ready3", 32'(req_ready), 32'b1000);
    wait_for(0, "to_start2", t_b);
    check("to_start_dist", 32'(t_b - t_done), 32'(GAP + TO + 2));
    drain("to_drain");

    // Reset mid-frame; the stale tx_done must not start anything.
    do_reset();
    expect_frame(8'h99, 2'd1, 1'b1);
    load(1, 8'h99, 1'b0);
    wait_for(0, "mid_start", t_a);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_locked", 32'(locked), 32'd0);
    check("mid_grant", 32'(grant_id), 32'd0);
    check("mid_din", 32'(tx_din), 32'd0);
    check("mid_start0", 32'(tx_start), 32'd0);
    t_b = 0;
    for (int d = 0; d < DONE_CLKS + 10; d++) begin
      @(negedge clk);
      if (tx_start) t_b++;
    end
    check("mid_no_stale_start", 32'(t_b), 32'd0);
    expect_frame(8'hC0, 2'd0, 1'b0);
    expect_frame(8'hC3, 2'd3, 1'b0);
    load(3, 8'hC3, 1'b1);
    load(0, 8'hC0, 1'b1);
    drain("mid_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
